// File: rtl/systolic_matmul_stream_if.sv
// Stream bundle for the systolic matrix-vector engine: weight rows in, input vectors in, result vectors out.
// Optional counter signals exist only when SYSTOLIC_PERF_CNT_EN is defined.
interface systolic_matmul_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
);
    logic                    w_valid;
    logic                    w_ready;
    logic [N*DATA_WIDTH-1:0] w_row;
    logic                    x_valid;
    logic                    x_ready;
    logic [N*DATA_WIDTH-1:0] x_in;
    logic                    y_valid;
    logic                    y_ready;
    logic [N*ACC_WIDTH-1:0]  y_out;
    logic                    weights_loaded;
`ifdef SYSTOLIC_PERF_CNT_EN
    logic                    perf_clear;
    logic [31:0]             stall_cycles;
    logic [31:0]             vectors_done;
`endif

    modport slave (
`ifdef SYSTOLIC_PERF_CNT_EN
        input  perf_clear,
        output stall_cycles, vectors_done,
`endif
        input  w_valid, w_row, x_valid, x_in, y_ready,
        output w_ready, x_ready, y_valid, y_out, weights_loaded
    );

    modport master (
`ifdef SYSTOLIC_PERF_CNT_EN
        output perf_clear,
        input  stall_cycles, vectors_done,
`endif
        output w_valid, w_row, x_valid, x_in, y_ready,
        input  w_ready, x_ready, y_valid, y_out, weights_loaded
    );
endinterface

// File: rtl/systolic_matmul_stream.sv
// Weight-stationary NxN systolic engine, y[j] = sum_i x[i]*W[i][j]; 2N-cycle latency, one vector/cycle.
// A held output freezes the whole pipeline (global stall); SYSTOLIC_PERF_CNT_EN adds stall/done counters.
module systolic_matmul_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
    input logic                     clk,
    input logic                     reset_n,
    systolic_matmul_stream_if.slave bus
);
    localparam int DEPTH = 2*N;
    localparam int CNT_W = $clog2(2*N + 2);
    localparam int RW    = $clog2(N);
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [DEPTH-1:0]      vld_q;
    logic                  y_vld_q;
    logic [N*ACC_WIDTH-1:0] y_q;

    logic advance, w_rdy, x_rdy, w_fire, x_fire, y_fire;

    logic signed [DATA_WIDTH-1:0] w_q     [N][N];
    logic signed [DATA_WIDTH-1:0] skew_out[N];
    logic signed [DATA_WIDTH-1:0] xr_q    [N][N-1];
    logic signed [DATA_WIDTH-1:0] pe_x    [N][N];
    logic signed [ACC_WIDTH-1:0]  prod    [N][N];
    logic signed [ACC_WIDTH-1:0]  ps_q    [N][N];
    logic signed [ACC_WIDTH-1:0]  col_out [N];

    assign advance = !(y_vld_q && !bus.y_ready);
    assign w_fire  = bus.w_valid && w_rdy;
    assign x_fire  = bus.x_valid && x_rdy;
    assign y_fire  = y_vld_q && bus.y_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        w_rdy   = 1'b0;
        x_rdy   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                w_rdy = 1'b1;
                if (bus.w_valid) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_rdy = (inflight_q == '0) && !y_vld_q;
                // A reload takes the cycle; no vector may enter alongside the new row 0.
                x_rdy = advance && !(bus.w_valid && w_rdy);
                if (bus.w_valid && w_rdy) begin
                    row_d   = RW'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w_q[i][j] <= '0;
        end else if (w_fire) begin
            for (int j = 0; j < N; j++)
                w_q[row_q][j] <= bus.w_row[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Row i sees x[i] after i+1 advances; bubbles inject zero data.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DATA_WIDTH-1:0] sk_q [gi+1];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k <= gi; k++) sk_q[k] <= '0;
            end else if (advance) begin
                sk_q[0] <= x_fire ? bus.x_in[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= gi; k++) sk_q[k] <= sk_q[k-1];
            end
        end
        assign skew_out[gi] = sk_q[gi];
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pe_x[i][0] = skew_out[i];
            for (int j = 1; j < N; j++) pe_x[i][j] = xr_q[i][j-1];
            for (int j = 0; j < N; j++)
                prod[i][j] = ACC_WIDTH'(pe_x[i][j]) * ACC_WIDTH'(w_q[i][j]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++)     ps_q[i][j] <= '0;
                for (int j = 0; j < N - 1; j++) xr_q[i][j] <= '0;
            end
        end else if (advance) begin
            for (int j = 0; j < N; j++) ps_q[0][j] <= prod[0][j];
            for (int i = 1; i < N; i++)
                for (int j = 0; j < N; j++)
                    ps_q[i][j] <= ps_q[i-1][j] + prod[i][j];
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N - 1; j++)
                    xr_q[i][j] <= pe_x[i][j];
        end
    end

    // Column j finishes j cycles after column 0; delay it N-1-j so all columns line up.
    for (genvar gj = 0; gj < N; gj++) begin : g_deskew
        localparam int D = N - 1 - gj;
        if (D > 0) begin : g_dly
            logic signed [ACC_WIDTH-1:0] dq [D];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < D; k++) dq[k] <= '0;
                end else if (advance) begin
                    dq[0] <= ps_q[N-1][gj];
                    for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
                end
            end
            assign col_out[gj] = dq[D-1];
        end else begin : g_nodly
            assign col_out[gj] = ps_q[N-1][gj];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            y_vld_q <= 1'b0;
            y_q     <= '0;
        end else if (advance) begin
            vld_q   <= {vld_q[DEPTH-2:0], x_fire};
            y_vld_q <= vld_q[DEPTH-1];
            if (vld_q[DEPTH-1]) begin
                for (int j = 0; j < N; j++) y_q[j*ACC_WIDTH +: ACC_WIDTH] <= col_out[j];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (x_fire && !y_fire)      inflight_d = inflight_q + 1'b1;
        else if (!x_fire && y_fire) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) inflight_q <= '0;
        else          inflight_q <= inflight_d;
    end

    assign bus.w_ready        = w_rdy;
    assign bus.x_ready        = x_rdy;
    assign bus.y_valid        = y_vld_q;
    assign bus.y_out          = y_q;
    assign bus.weights_loaded = (state_q == ST_RUN);

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] stall_q, done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            done_q  <= '0;
        end else if (bus.perf_clear) begin
            stall_q <= '0;
            done_q  <= '0;
        end else begin
            if (!advance && (inflight_q != '0) && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (y_fire && (done_q != '1))                          done_q  <= done_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.vectors_done = done_q;
`endif
endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Randomised bench for systolic_matmul_stream against a plain-arithmetic matrix-vector model.
module tb_systolic_matmul_stream;
    localparam int DW  = 16;
    localparam int N   = 4;
    localparam int ACC = 2*DW + $clog2(N);

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    systolic_matmul_stream_if #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(ACC)) bus();

    systolic_matmul_stream #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(ACC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int wm [N][N];
    logic [N*DW-1:0]  stim_q[$];
    logic [N*ACC-1:0] exp_q[$];
    logic [N*ACC-1:0] last_y;

    function automatic logic [N*DW-1:0] pack_x(int a0, int a1, int a2, int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [N*ACC-1:0] pack_y(int a0, int a1, int a2, int a3);
        return {ACC'(a3), ACC'(a2), ACC'(a1), ACC'(a0)};
    endfunction

    function automatic logic [N*ACC-1:0] model_y(logic [N*DW-1:0] x);
        logic [N*ACC-1:0] r;
        longint s;
        logic signed [DW-1:0] xe;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                xe = x[i*DW +: DW];
                s += longint'(xe) * longint'(wm[i][j]);
            end
            r[j*ACC +: ACC] = s[ACC-1:0];
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bus.w_valid = 1'b0;
        bus.w_row   = '0;
        bus.x_valid = 1'b0;
        bus.x_in    = '0;
        bus.y_ready = 1'b1;
`ifdef SYSTOLIC_PERF_CNT_EN
        bus.perf_clear = 1'b0;
`endif
    endtask

    task automatic load_weights(input int start_row, input string name);
        int waitc;
        for (int r = start_row; r < N; r++) begin
            waitc = 0;
            @(negedge clk);
            bus.w_valid = 1'b1;
            for (int j = 0; j < N; j++) bus.w_row[j*DW +: DW] = DW'(wm[r][j]);
            #1;
            while (!bus.w_ready && waitc < 50) begin
                @(negedge clk); #1;
                waitc++;
            end
            if (!bus.w_ready) begin
                checks++; errors++;
                $display("FAIL %s: w_ready timeout row %0d got 0 want 1", name, r);
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic run_stream(input bit rnd, input int stall_at, input int stall_len,
                              input bit contig, input string name);
        int idx, got, cyc, last_cyc, nvec;
        bit prev_stall;
        logic [N*ACC-1:0] prev_y, exp;
        idx = 0; got = 0; cyc = 0; last_cyc = -1; prev_stall = 0; prev_y = '0;
        nvec = stim_q.size();
        exp_q.delete();
        while (got < nvec && cyc < 3000) begin
            @(negedge clk);
            bus.x_valid = (idx < nvec) && (!rnd || $urandom_range(0, 3) != 0);
            bus.x_in    = (idx < nvec) ? stim_q[idx] : '0;
            bus.y_ready = !((stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len)
                            || (rnd && $urandom_range(0, 2) == 0));
            #1;
            if (bus.y_valid && !bus.y_ready) begin
                checks++;
                if (bus.x_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s x_ready_in_stall: got %b want 0 (cyc %0d)", name, bus.x_ready, cyc);
                end
            end
            if (prev_stall) begin
                checks++;
                if (bus.y_valid !== 1'b1 || bus.y_out !== prev_y) begin
                    errors++;
                    $display("FAIL %s hold: got v=%b %h want v=1 %h", name, bus.y_valid, bus.y_out, prev_y);
                end
            end
            prev_stall = bus.y_valid && !bus.y_ready;
            prev_y     = bus.y_out;
            if (bus.y_valid && bus.y_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_y: got %h want none", name, bus.y_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.y_out !== exp) begin
                        errors++;
                        $display("FAIL %s y[%0d]: got %h want %h", name, got, bus.y_out, exp);
                    end
                end
                if (contig && got > 0) begin
                    checks++;
                    if (cyc != last_cyc + 1) begin
                        errors++;
                        $display("FAIL %s gap: got cycle %0d want %0d", name, cyc, last_cyc + 1);
                    end
                end
                last_cyc = cyc;
                last_y   = bus.y_out;
                got++;
            end
            if (bus.x_valid && bus.x_ready) begin
                exp_q.push_back(model_y(stim_q[idx]));
                idx++;
            end
            cyc++;
        end
        checks++;
        if (got != nvec || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s count: got %0d results want %0d", name, got, nvec);
        end
        @(negedge clk);
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;
        stim_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (bus.w_ready !== 1'b1)        begin errors++; $display("FAIL reset w_ready: got %b want 1", bus.w_ready); end
        if (bus.x_ready !== 1'b0)        begin errors++; $display("FAIL reset x_ready: got %b want 0", bus.x_ready); end
        if (bus.y_valid !== 1'b0)        begin errors++; $display("FAIL reset y_valid: got %b want 0", bus.y_valid); end
        if (bus.y_out !== '0)            begin errors++; $display("FAIL reset y_out: got %h want 0", bus.y_out); end
        if (bus.weights_loaded !== 1'b0) begin errors++; $display("FAIL reset weights_loaded: got %b want 0", bus.weights_loaded); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_identity();
        int c;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = (i == j) ? 1 : 0;
        load_weights(0, "identity");
        #1;
        checks++;
        if (bus.weights_loaded !== 1'b1) begin errors++; $display("FAIL identity weights_loaded: got %b want 1", bus.weights_loaded); end
        bus.x_valid = 1'b1;
        bus.x_in    = pack_x(1, 2, 3, 4);
        #1;
        checks++;
        if (bus.x_ready !== 1'b1) begin errors++; $display("FAIL identity x_ready: got %b want 1", bus.x_ready); end
        @(posedge clk);
        c = 0;
        @(negedge clk);
        bus.x_valid = 1'b0;
        #1;
        while (!bus.y_valid && c < 40) begin
            @(posedge clk); c++;
            @(negedge clk); #1;
        end
        checks += 2;
        if (c != 2*N) begin errors++; $display("FAIL identity latency: got %0d want %0d", c, 2*N); end
        if (bus.y_out !== pack_y(1, 2, 3, 4)) begin errors++; $display("FAIL identity y: got %h want %h", bus.y_out, pack_y(1, 2, 3, 4)); end
        @(negedge clk); #1;
        checks++;
        if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL identity y_valid_after: got %b want 0", bus.y_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = i + 1;
        load_weights(0, "b2b");
        for (int k = 1; k <= 8; k++) stim_q.push_back(pack_x(k, k, k, k));
        run_stream(1'b0, -1, 0, 1'b1, "b2b");
        checks++;
        if (last_y !== pack_y(80, 80, 80, 80)) begin errors++; $display("FAIL b2b last: got %h want %h", last_y, pack_y(80, 80, 80, 80)); end
    endtask

    task automatic test_stall();
        for (int k = 1; k <= 12; k++) stim_q.push_back(pack_x(k, k, k, k));
        run_stream(1'b0, 8, 5, 1'b0, "stall");
        checks++;
        if (last_y !== pack_y(120, 120, 120, 120)) begin errors++; $display("FAIL stall last: got %h want %h", last_y, pack_y(120, 120, 120, 120)); end
    endtask

    task automatic test_signed();
        logic [ACC-1:0] big;
        big = '0;
        big[32] = 1'b1;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = -32768;
        load_weights(0, "neg");
        stim_q.push_back(pack_x(-32768, -32768, -32768, -32768));
        run_stream(1'b0, -1, 0, 1'b0, "neg");
        checks++;
        if (last_y !== {big, big, big, big}) begin errors++; $display("FAIL neg y: got %h want %h", last_y, {big, big, big, big}); end
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = (i == j) ? 1 : 0;
        load_weights(0, "mixed");
        stim_q.push_back(pack_x(3, -5, 0, 7));
        run_stream(1'b0, -1, 0, 1'b0, "mixed");
        checks++;
        if (last_y !== pack_y(3, -5, 0, 7)) begin errors++; $display("FAIL mixed y: got %h want %h", last_y, pack_y(3, -5, 0, 7)); end
    endtask

    task automatic test_reload();
        int outstanding, c;
        bit fired;
        logic [N*ACC-1:0] exp;
        outstanding = 0; c = 0; fired = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = i + 1;
        load_weights(0, "reload_pre");
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            bus.x_valid = 1'b1;
            bus.x_in    = pack_x(k + 1, 2, -3, k);
            #1;
            if (bus.x_ready) begin exp_q.push_back(model_y(bus.x_in)); outstanding++; end
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = (i == j) ? 2 : 0;
        bus.x_valid = 1'b0;
        bus.w_valid = 1'b1;
        for (int j = 0; j < N; j++) bus.w_row[j*DW +: DW] = DW'(wm[0][j]);
        while (!fired && c < 100) begin
            #1;
            if (outstanding > 0) begin
                checks++;
                if (bus.w_ready !== 1'b0) begin errors++; $display("FAIL reload w_ready_busy: got %b want 0 (%0d in flight)", bus.w_ready, outstanding); end
            end
            if (bus.y_valid && bus.y_ready) begin
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (bus.y_out !== exp) begin errors++; $display("FAIL reload drain y: got %h want %h", bus.y_out, exp); end
                outstanding--;
            end
            if (bus.w_ready) fired = 1'b1;
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        bus.w_valid = 1'b0;
        checks++;
        if (!fired || outstanding != 0) begin errors++; $display("FAIL reload accept: got fired=%0d left=%0d want fired=1 left=0", fired, outstanding); end
        load_weights(1, "reload");
        #1;
        checks++;
        if (bus.weights_loaded !== 1'b1) begin errors++; $display("FAIL reload weights_loaded: got %b want 1", bus.weights_loaded); end
        stim_q.push_back(pack_x(1, 1, 1, 1));
        run_stream(1'b0, -1, 0, 1'b0, "reload");
        checks++;
        if (last_y !== pack_y(2, 2, 2, 2)) begin errors++; $display("FAIL reload y: got %h want %h", last_y, pack_y(2, 2, 2, 2)); end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] t;
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            t = DW'($urandom);
            wm[i][j] = t;
        end
        load_weights(0, "random");
        for (int k = 0; k < 40; k++) begin
            v = {$urandom, $urandom};
            stim_q.push_back(v);
        end
        run_stream(1'b1, -1, 0, 1'b0, "random");
    endtask

    task automatic test_async_reset();
        int c;
        c = 0;
        @(negedge clk);
        bus.y_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.x_valid = 1'b1;
            bus.x_in    = pack_x(k, k + 1, k + 2, k + 3);
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
        #1;
        while (!bus.y_valid && c < 30) begin @(negedge clk); #1; c++; end
        checks++;
        if (bus.y_valid !== 1'b1) begin errors++; $display("FAIL areset pre y_valid: got %b want 1", bus.y_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (bus.y_valid !== 1'b0)        begin errors++; $display("FAIL areset y_valid: got %b want 0", bus.y_valid); end
        if (bus.y_out !== '0)            begin errors++; $display("FAIL areset y_out: got %h want 0", bus.y_out); end
        if (bus.weights_loaded !== 1'b0) begin errors++; $display("FAIL areset weights_loaded: got %b want 0", bus.weights_loaded); end
        if (bus.w_ready !== 1'b1)        begin errors++; $display("FAIL areset w_ready: got %b want 1", bus.w_ready); end
        if (bus.x_ready !== 1'b0)        begin errors++; $display("FAIL areset x_ready: got %b want 0", bus.x_ready); end
        @(negedge clk);
        reset_n     = 1'b1;
        bus.y_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks += 3;
        if (bus.w_ready !== 1'b1) begin errors++; $display("FAIL release w_ready: got %b want 1", bus.w_ready); end
        if (bus.x_ready !== 1'b0) begin errors++; $display("FAIL release x_ready: got %b want 0", bus.x_ready); end
        if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL release y_valid: got %b want 0", bus.y_valid); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_stall();
        test_signed();
        test_reload();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_matmul_stream.md
Name: systolic_matmul_stream

Overview:
- Weight-stationary NxN systolic matrix-vector engine, the streaming successor of the team's fixed-function array.
- Computes y[j] = sum over i of x[i]*W[i][j] for a continuous stream of input vectors.
- Adds internal input skew, output deskew, valid/ready handshakes on every stream, sequenced row-wise weight loading, signed wide accumulation and global back-pressure stall.
- Sits between the vector feeder and the softmax datapath.

Parameters:
- DATA_WIDTH, 16, signed width of each x and W element.
- N, 4, array dimension (rows = input elements, cols = output elements); N >= 2.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), signed width of partial sums and outputs.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- w_valid  in  1  weight row present.
- w_ready  out  1  engine accepts a weight row.
- w_row  in  N*DATA_WIDTH  one row W[r][0..N-1], element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- x_valid  in  1  input vector present.
- x_ready  out  1  engine accepts an input vector.
- x_in  in  N*DATA_WIDTH  x[0..N-1], element i at [i*DATA_WIDTH +: DATA_WIDTH].
- y_valid  out  1  result vector valid.
- y_ready  in  1  downstream accepts the result.
- y_out  out  N*ACC_WIDTH  y[0..N-1], element j at [j*ACC_WIDTH +: ACC_WIDTH].
- weights_loaded  out  1  all N rows of the current weight set are resident.

Behaviour:
- Reset (async assert, sync release): all PE weights, skew/deskew registers, partial sums, in-flight counter and row counter clear to 0. Outputs: w_ready=1, x_ready=0, y_valid=0, y_out=0, weights_loaded=0. FSM enters LOAD.
- FSM states:
  - LOAD: w_ready=1, x_ready=0. Each w_valid&&w_ready cycle writes W[r] (r = row counter 0..N-1) into PE row r; r increments. After row N-1 is written: r wraps to 0, weights_loaded=1, next state RUN.
  - RUN: x_ready = advance. An x_valid&&x_ready transfer injects the vector. w_ready=1 only when in-flight count==0 and no y_valid is pending. A w_valid&&w_ready transfer writes row 0, clears weights_loaded and enters LOAD; that vector is then row 0 of the new set.
- advance = !(y_valid && !y_ready). Every pipeline register (skew, PE, deskew, output) updates only when advance=1. When advance=0 everything holds, and y_out/y_valid stay stable until accepted.
- Skew/deskew:
  - x[i] is delayed i advancing cycles before entering row i.
  - x moves one column right per advance; psum moves one row down per advance; row 0 psum_in = 0.
  - Column j output is delayed N-1-j advancing cycles, then all columns pass through one output register.
- Latency: exactly 2N advancing cycles from the x handshake to y_valid=1 for that vector (N=4: 8 cycles). Throughput is one vector per cycle; results come out in input order.
- Bubbles: a cycle with no x transfer injects a bubble. The valid bit travels with the data, so bubbles never produce y_valid.
- Arithmetic: x and W are signed. Products are sign-extended to ACC_WIDTH, and sums wrap modulo 2^ACC_WIDTH (two's complement, no saturation).
- In-flight counter: +1 on x transfer, -1 on y transfer, both in the same cycle = no change. Maximum value is 2N+1.
- Reset mid-operation: in-flight vectors are discarded, loaded weights are lost, weights_loaded drops asynchronously.

Optional Feature:
- Macro SYSTOLIC_PERF_CNT_EN.
- When defined, three extra outputs are added:
  - stall_cycles (32 bits): counts cycles with advance=0 and in-flight>0.
  - vectors_done (32 bits): counts y transfers.
  - both counters saturate at all-ones and reset to 0.
  - perf_clear (input, 1 bit): synchronous clear of both counters.
- When undefined, these ports and their logic do not exist and behaviour is otherwise identical.

Test Plan:
- Load identity W (N=4, DATA_WIDTH=16); send x=(1,2,3,4) -> y=(1,2,3,4), y_valid exactly 8 cycles after the handshake, weights_loaded=1 after the 4th row.
- W[i][j]=i+1; send 8 back-to-back vectors x=(k,k,k,k) for k=1..8 with y_ready=1 -> y_valid on 8 consecutive cycles, each y[j]=10k, in order.
- Same stream with y_ready held 0 for 5 cycles mid-stream -> x_ready=0 during the stall, y_out stable, no loss or duplication, order preserved.
- W all -32768, x all -32768 -> y[j] = 4*2^30 = 2^32 (fits ACC_WIDTH=34). Mixed signs x=(3,-5,0,7), W=identity -> y=(3,-5,0,7).
- Reload attempt: w_valid while vectors are in flight -> w_ready=0 until drained. After drain, load W=2*identity, send x=(1,1,1,1) -> y=(2,2,2,2).
- Assert reset_n=0 asynchronously with 3 vectors in flight -> y_valid=0, y_out=0, weights_loaded=0 immediately; after release w_ready=1, x_ready=0.
